// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, LSB first, mid-bit sampling behind a 2-flop synchroniser.
// Latency: byte valid one cycle after the stop-bit sample (mid-stop-bit plus 2 sync cycles).
// Backpressure: none on the line; an unacked byte is kept and later bytes set the sticky overrun flag.
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUDRATE = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ack_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          dlv_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            dlv_vld     <= 1'b0;
            data_o      <= 8'd0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_s        <= rx_meta;
            dlv_vld     <= 1'b0;
            frame_err_o <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        // A start bit that is already high again at mid-bit is a glitch.
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            dlv_vld <= 1'b1;
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BRK: begin
                    // Held-low line: one error only, wait for the line to return idle.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            if (dlv_vld) begin
                if (!valid_o) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else if (ack_i) begin
                    data_o    <= shreg;
                    overrun_o <= 1'b0;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ack_i) begin
                valid_o   <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboarded bench for uart_rx_8n1 at 25 clocks per bit: directed scenarios plus random frames.
module tb_uart_rx_8n1;

    localparam int CPB = 25;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i  = 1'b1;
    logic       ack_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx_8n1 #(
        .CLK_FREQ(25000000),
        .BAUDRATE(1000000)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ack_i      (ack_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #20 clk_i = ~clk_i;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         fe_cnt     = 0;
    int         ovr_cycles = 0;
    int         rx_cnt     = 0;
    bit         ack_en     = 1'b0;
    int         ack_delay  = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Line model: start bit 0, eight data bits LSB first, stop bit; each held CPB clocks.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int max_cyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10 * CPB && i < max_cyc; i++) begin
            rx_i = bits[i / CPB];
            cyc(1);
        end
    endtask

    task automatic send(input logic [7:0] d);
        exp_q.push_back(d);
        drive_frame(d, 1'b1, 10 * CPB);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k;
        k = 0;
        while (!valid_o && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(valid_o), 32'd1);
    endtask

    // Monitor: a new byte is presented when valid rises, or stays high after an accepted ack.
    initial begin : monitor
        logic pv;
        logic pa;
        pv = 1'b0;
        pa = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && valid_o && (!pv || pa)) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", data_o);
                end else begin
                    chk("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err_o) fe_cnt++;
            if (overrun_o) ovr_cycles++;
            pv = valid_o;
            pa = ack_i;
        end
    end

    initial begin : acker
        int wcnt;
        wcnt = 0;
        forever begin
            cyc(1);
            if (ack_en) begin
                if (valid_o && !ack_i) begin
                    if (wcnt >= ack_delay) begin
                        ack_i = 1'b1;
                        wcnt  = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    ack_i = 1'b0;
                    wcnt  = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #(40 * 80000);
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fe0, ovr0, rx0, exp_fe;
        logic [7:0] d;

        // Reset state
        rst_i = 1'b1;
        cyc(3);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_ferr", 32'(frame_err_o), 32'h0);
        chk("rst_ovr", 32'(overrun_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;
        cyc(5);

        // 1: single frame, manual ack a few cycles after valid
        send(8'h35);
        wait_valid(50, "t1_valid");
        chk("t1_data", 32'(data_o), 32'h35);
        cyc(2);
        chk("t1_valid_held", 32'(valid_o), 32'd1);
        chk("t1_no_ovr", 32'(overrun_o), 32'd0);
        ack_i = 1'b1;
        cyc(1);
        ack_i = 1'b0;
        chk("t1_valid_cleared", 32'(valid_o), 32'd0);
        chk("t1_ferr_count", 32'(fe_cnt), 32'd0);

        // 2: start-bit glitches are rejected
        rx0 = rx_cnt;
        rx_i = 1'b0;
        cyc(5);
        rx_i = 1'b1;
        cyc(3);
        chk("t2_busy_during", 32'(busy_o), 32'd1);
        cyc(20);
        chk("t2_busy_after", 32'(busy_o), 32'd0);
        for (int g = 0; g < 4; g++) begin
            rx_i = 1'b0;
            cyc($urandom_range(1, 9));
            rx_i = 1'b1;
            cyc(30);
            chk("t2_rand_glitch_idle", 32'(busy_o), 32'd0);
        end
        chk("t2_no_byte", 32'(rx_cnt - rx0), 32'd0);
        chk("t2_valid", 32'(valid_o), 32'd0);

        // 3: framing error, line held low, then a clean frame
        ack_en    = 1'b1;
        ack_delay = 2;
        fe0 = fe_cnt;
        drive_frame(8'hA5, 1'b0, 10 * CPB);
        cyc(100);
        chk("t3_ferr_once", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_valid", 32'(valid_o), 32'd0);
        chk("t3_busy_break", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        cyc(10);
        chk("t3_idle", 32'(busy_o), 32'd0);
        send(8'h0F);
        cyc(20);
        chk("t3_rx_done", 32'(exp_q.size()), 32'd0);

        // 4: back-to-back frames, immediate ack
        ack_delay = 0;
        rx0  = rx_cnt;
        ovr0 = ovr_cycles;
        for (int b = 8'h30; b <= 8'h39; b++) send(8'(b));
        cyc(30);
        chk("t4_count", 32'(rx_cnt - rx0), 32'd10);
        chk("t4_no_ovr", 32'(ovr_cycles - ovr0), 32'd0);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: overrun when the first byte is never acked
        ack_en = 1'b0;
        cyc(5);
        send(8'h11);
        drive_frame(8'h22, 1'b1, 10 * CPB);
        cyc(10);
        chk("t5_data", 32'(data_o), 32'h11);
        chk("t5_valid", 32'(valid_o), 32'd1);
        chk("t5_ovr", 32'(overrun_o), 32'd1);
        ack_i = 1'b1;
        cyc(1);
        ack_i = 1'b0;
        cyc(1);
        chk("t5_valid_after_ack", 32'(valid_o), 32'd0);
        chk("t5_ovr_after_ack", 32'(overrun_o), 32'd0);

        // 6: reset in the middle of a frame
        ack_en = 1'b1;
        drive_frame(8'h55, 1'b1, 100);
        rst_i = 1'b1;
        cyc(2);
        chk("t6_rst_data", 32'(data_o), 32'h0);
        chk("t6_rst_valid", 32'(valid_o), 32'h0);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        chk("t6_rst_ovr", 32'(overrun_o), 32'h0);
        rst_i = 1'b0;
        rx_i  = 1'b1;
        cyc(20);
        rx0 = rx_cnt;
        send(8'hC3);
        cyc(20);
        chk("t6_one_byte", 32'(rx_cnt - rx0), 32'd1);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        // 7: random bytes, random ack delays and gaps, occasional bad stop bits
        fe0    = fe_cnt;
        ovr0   = ovr_cycles;
        exp_fe = 0;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            ack_delay = $urandom_range(0, 20);
            if ($urandom_range(0, 4) == 0) begin
                drive_frame(d, 1'b0, 10 * CPB);
                rx_i = 1'b1;
                exp_fe++;
                cyc($urandom_range(5, 20));
            end else begin
                send(d);
                cyc($urandom_range(0, 20));
            end
        end
        cyc(40);
        chk("t7_ferr_count", 32'(fe_cnt - fe0), 32'(exp_fe));
        chk("t7_no_ovr", 32'(ovr_cycles - ovr0), 32'd0);
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_valid", 32'(valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
